// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, control-word bit
// positions, microstep count and per-opcode instruction lengths.
package control_sequencer_pkg;

   // Opcodes (instruction register upper nibble)
   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpLda = 4'h1;
   localparam logic [3:0] OpAdd = 4'h2;
   localparam logic [3:0] OpSub = 4'h3;
   localparam logic [3:0] OpSta = 4'h4;
   localparam logic [3:0] OpLdi = 4'h5;
   localparam logic [3:0] OpJmp = 4'h6;
   localparam logic [3:0] OpJc  = 4'h7;
   localparam logic [3:0] OpJz  = 4'h8;
   localparam logic [3:0] OpOut = 4'hE;
   localparam logic [3:0] OpHlt = 4'hF;

   // Control word bit positions (active high)
   localparam int unsigned CwHlt = 15;
   localparam int unsigned CwMi  = 14;
   localparam int unsigned CwRi  = 13;
   localparam int unsigned CwRo  = 12;
   localparam int unsigned CwIo  = 11;
   localparam int unsigned CwIi  = 10;
   localparam int unsigned CwAi  = 9;
   localparam int unsigned CwAo  = 8;
   localparam int unsigned CwEo  = 7;
   localparam int unsigned CwSu  = 6;
   localparam int unsigned CwBi  = 5;
   localparam int unsigned CwOi  = 4;
   localparam int unsigned CwCe  = 3;
   localparam int unsigned CwCo  = 2;
   localparam int unsigned CwJ   = 1;
   localparam int unsigned CwFi  = 0;

   // Microsteps per instruction slot and the last step index
   localparam int unsigned NumSteps = 5;
   localparam logic [2:0]  LastStep = 3'(NumSteps - 1);

   // Instruction length in steps, indexed by opcode (flag independent)
   localparam logic [15:0][2:0] InstrLen = {
      3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,  // F..8
      3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd5, 3'd4, 3'd3   // 7..0
   };

   // Sequencer run state
   typedef enum logic [1:0] {
      StStart,  // first clock after reset: hold fetch step
      StRun,
      StHalt
   } seq_state_e;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word.
module microcode_rom
   import control_sequencer_pkg::*;
(
   input  logic [3:0]  opcode_i,
   input  logic [2:0]  step_i,
   input  logic        carry_flag_i,
   input  logic        zero_flag_i,
   output logic [15:0] control_word_o
);

   // Decode the control word for the current step
   always_comb begin
      control_word_o = '0;
      case (step_i)
         3'd0: begin
            control_word_o[CwCo] = 1'b1;
            control_word_o[CwMi] = 1'b1;
         end
         3'd1: begin
            control_word_o[CwRo] = 1'b1;
            control_word_o[CwIi] = 1'b1;
            control_word_o[CwCe] = 1'b1;
         end
         default: begin
            case (opcode_i)
               OpNop: ;
               OpLda: begin
                  if (step_i == 3'd2) begin
                     control_word_o[CwIo] = 1'b1;
                     control_word_o[CwMi] = 1'b1;
                  end else if (step_i == 3'd3) begin
                     control_word_o[CwRo] = 1'b1;
                     control_word_o[CwAi] = 1'b1;
                  end
               end
               OpAdd, OpSub: begin
                  if (step_i == 3'd2) begin
                     control_word_o[CwIo] = 1'b1;
                     control_word_o[CwMi] = 1'b1;
                  end else if (step_i == 3'd3) begin
                     control_word_o[CwRo] = 1'b1;
                     control_word_o[CwBi] = 1'b1;
                  end else if (step_i == 3'd4) begin
                     control_word_o[CwEo] = 1'b1;
                     control_word_o[CwAi] = 1'b1;
                     control_word_o[CwFi] = 1'b1;
                     control_word_o[CwSu] = (opcode_i == OpSub);
                  end
               end
               OpSta: begin
                  if (step_i == 3'd2) begin
                     control_word_o[CwIo] = 1'b1;
                     control_word_o[CwMi] = 1'b1;
                  end else if (step_i == 3'd3) begin
                     control_word_o[CwAo] = 1'b1;
                     control_word_o[CwRi] = 1'b1;
                  end
               end
               OpLdi: begin
                  if (step_i == 3'd2) begin
                     control_word_o[CwIo] = 1'b1;
                     control_word_o[CwAi] = 1'b1;
                  end
               end
               OpJmp, OpJc, OpJz: begin
                  // Conditional jumps look at the flags only in step 2
                  if ((step_i == 3'd2) &&
                      ((opcode_i == OpJmp) ||
                       ((opcode_i == OpJc) && carry_flag_i) ||
                       ((opcode_i == OpJz) && zero_flag_i))) begin
                     control_word_o[CwIo] = 1'b1;
                     control_word_o[CwJ]  = 1'b1;
                  end
               end
               OpOut: begin
                  if (step_i == 3'd2) begin
                     control_word_o[CwAo] = 1'b1;
                     control_word_o[CwOi] = 1'b1;
                  end
               end
               OpHlt: begin
                  if (step_i == 3'd2) begin
                     control_word_o[CwHlt] = 1'b1;
                  end
               end
               default: ;  // 1001-1101 behave as NOP
            endcase
         end
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer: step counter, halt latch and wrap logic around the
// microcode ROM.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic        clk,
   input  logic        n_clear,
   input  logic [3:0]  opcode,
   input  logic        carry_flag,
   input  logic        zero_flag,
   output logic [15:0] control_word,
   output logic [2:0]  step,
   output logic        halted
);

   seq_state_e  state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [2:0]  last_step;
   logic [15:0] rom_cw;

   microcode_rom u_rom (
      .opcode_i       (opcode),
      .step_i         (step_q),
      .carry_flag_i   (carry_flag),
      .zero_flag_i    (zero_flag),
      .control_word_o (rom_cw)
   );

   // Last step index of the current instruction
   always_comb begin
      last_step = EARLY_EXIT ? (InstrLen[opcode] - 3'd1) : LastStep;
   end

   // Next state: hold after reset, advance/wrap while running, freeze on HLT
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      case (state_q)
         StStart: state_d = StRun;
         StRun: begin
            if (rom_cw[CwHlt]) begin
               state_d = StHalt;
            end else if (step_q == last_step) begin
               step_d = '0;
            end else begin
               step_d = step_q + 3'd1;
            end
         end
         StHalt: ;
         default: begin
            state_d = StStart;
            step_d  = '0;
         end
      endcase
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge n_clear) begin
      if (!n_clear) begin
         state_q <= StStart;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   // Output word: clear forces zero immediately, halt forces HLT only
   always_comb begin
      control_word = '0;
      if (!n_clear) begin
         control_word = '0;
      end else if (state_q == StHalt) begin
         control_word[CwHlt] = 1'b1;
      end else begin
         control_word = rom_cw;
      end
   end

   assign step   = step_q;
   assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (EARLY_EXIT 0 and 1) checked
// every cycle against an instruction-level model, plus directed vectors.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        n_clear = 1'b0;
   logic [3:0]  opcode = 4'h0;
   logic        carry = 1'b0;
   logic        zero = 1'b0;
   logic [15:0] cw0, cw1;
   logic [2:0]  st0, st1;
   logic        h0, h1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   control_sequencer #(.EARLY_EXIT(1'b0)) u_ee0 (
      .clk          (clk),
      .n_clear      (n_clear),
      .opcode       (opcode),
      .carry_flag   (carry),
      .zero_flag    (zero),
      .control_word (cw0),
      .step         (st0),
      .halted       (h0)
   );

   control_sequencer #(.EARLY_EXIT(1'b1)) u_ee1 (
      .clk          (clk),
      .n_clear      (n_clear),
      .opcode       (opcode),
      .carry_flag   (carry),
      .zero_flag    (zero),
      .control_word (cw1),
      .step         (st1),
      .halted       (h1)
   );

   // Word an instruction presents at a given step
   function automatic logic [15:0] exp_word(input logic [3:0] op, input int st,
                                            input logic c, input logic z);
      logic [15:0] w [5];
      w[0] = 16'h4004;
      w[1] = 16'h1408;
      w[2] = 16'h0000;
      w[3] = 16'h0000;
      w[4] = 16'h0000;
      case (op)
         4'h1: begin w[2] = 16'h4800; w[3] = 16'h1200; end
         4'h2: begin w[2] = 16'h4800; w[3] = 16'h1020; w[4] = 16'h0281; end
         4'h3: begin w[2] = 16'h4800; w[3] = 16'h1020; w[4] = 16'h02C1; end
         4'h4: begin w[2] = 16'h4800; w[3] = 16'h2100; end
         4'h5: w[2] = 16'h0A00;
         4'h6: w[2] = 16'h0802;
         4'h7: if (c) w[2] = 16'h0802;
         4'h8: if (z) w[2] = 16'h0802;
         4'hE: w[2] = 16'h0110;
         4'hF: w[2] = 16'h8000;
         default: ;
      endcase
      if (st < 0 || st > 4) return 16'h0000;
      return w[st];
   endfunction

   function automatic int instr_len(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         default:    return 3;
      endcase
   endfunction

   // Model state per instance: index 0 = EARLY_EXIT 0, index 1 = EARLY_EXIT 1
   int m_step [2];
   bit m_halt [2];
   bit m_fresh [2];

   always @(posedge clk or negedge n_clear) begin
      for (int i = 0; i < 2; i++) begin
         if (!n_clear) begin
            m_step[i]  <= 0;
            m_halt[i]  <= 1'b0;
            m_fresh[i] <= 1'b1;
         end else if (m_halt[i]) begin
            m_halt[i] <= 1'b1;
         end else if (m_fresh[i]) begin
            m_fresh[i] <= 1'b0;
         end else if (exp_word(opcode, m_step[i], carry, zero) == 16'h8000) begin
            m_halt[i] <= 1'b1;
         end else if (m_step[i] + 1 >= ((i == 1) ? instr_len(opcode) : 5)) begin
            m_step[i] <= 0;
         end else begin
            m_step[i] <= m_step[i] + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      logic [15:0] e0, e1;
      e0 = !n_clear ? 16'h0000 : m_halt[0] ? 16'h8000 : exp_word(opcode, m_step[0], carry, zero);
      e1 = !n_clear ? 16'h0000 : m_halt[1] ? 16'h8000 : exp_word(opcode, m_step[1], carry, zero);
      chk("model_ee0_cw", cw0, e0);
      chk("model_ee0_step", 16'(st0), 16'(m_step[0]));
      chk("model_ee0_halted", 16'(h0), 16'(m_halt[0]));
      chk("model_ee1_cw", cw1, e1);
      chk("model_ee1_step", 16'(st1), 16'(m_step[1]));
      chk("model_ee1_halted", 16'(h1), 16'(m_halt[1]));
   end

   // Reset with a new opcode/flags, check the cleared state, then release
   task automatic start(input logic [3:0] op, input logic c, input logic z);
      @(posedge clk);
      #2;
      n_clear = 1'b0;
      opcode = op;
      carry = c;
      zero = z;
      @(negedge clk);
      chk("rst_cw", cw1, 16'h0000);
      chk("rst_step", 16'(st1), 16'h0000);
      chk("rst_halted", 16'(h1), 16'h0000);
      @(posedge clk);
      #2;
      n_clear = 1'b1;
   endtask

   // Wait for the next sample point and check one instance directly
   task automatic cyc(input string tag, input bit ee1, input logic [15:0] w, input int s);
      @(negedge clk);
      chk({tag, "_cw"}, ee1 ? cw1 : cw0, w);
      chk({tag, "_step"}, 16'(ee1 ? st1 : st0), 16'(s));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // LDA: fetch held one extra cycle after release, then 4 steps
      start(4'h1, 1'b0, 1'b0);
      cyc("lda0", 1'b1, 16'h4004, 0);
      cyc("lda0h", 1'b1, 16'h4004, 0);
      cyc("lda1", 1'b1, 16'h1408, 1);
      cyc("lda2", 1'b1, 16'h4800, 2);
      cyc("lda3", 1'b1, 16'h1200, 3);
      cyc("lda_wrap", 1'b1, 16'h4004, 0);

      // SUB and ADD: five steps each
      start(4'h3, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      cyc("sub3", 1'b1, 16'h1020, 3);
      cyc("sub4", 1'b1, 16'h02C1, 4);
      cyc("sub_wrap", 1'b1, 16'h4004, 0);
      start(4'h2, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      cyc("add4", 1'b1, 16'h0281, 4);
      cyc("add_wrap", 1'b1, 16'h4004, 0);

      // JC taken and not taken
      start(4'h7, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      cyc("jc_c1", 1'b1, 16'h0802, 2);
      cyc("jc_c1_wrap", 1'b1, 16'h4004, 0);
      start(4'h7, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      cyc("jc_c0", 1'b1, 16'h0000, 2);
      cyc("jc_c0_wrap", 1'b1, 16'h4004, 0);

      // HLT: freeze at step 2, ignore opcode/flag changes, clear via n_clear
      start(4'hF, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      cyc("hlt2", 1'b1, 16'h8000, 2);
      chk("hlt2_halted", 16'(h1), 16'h0000);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #2;
         opcode = opcode ^ 4'hA;
         carry = ~carry;
         zero = ~zero;
         cyc("halt_hold", 1'b1, 16'h8000, 2);
         chk("halt_hold_halted", 16'(h1), 16'h0001);
      end
      #1;
      n_clear = 1'b0;
      #1;
      chk("halt_clr_step", 16'(st1), 16'h0000);
      chk("halt_clr_halted", 16'(h1), 16'h0000);
      chk("halt_clr_cw", cw1, 16'h0000);

      // EARLY_EXIT=0 LDI runs all five steps; clear lands mid-instruction
      start(4'h5, 1'b0, 1'b0);
      cyc("ldi0", 1'b0, 16'h4004, 0);
      cyc("ldi0h", 1'b0, 16'h4004, 0);
      cyc("ldi1", 1'b0, 16'h1408, 1);
      cyc("ldi2", 1'b0, 16'h0A00, 2);
      cyc("ldi3", 1'b0, 16'h0000, 3);
      #1;
      n_clear = 1'b0;
      #1;
      chk("ldi_clr_step", 16'(st0), 16'h0000);
      chk("ldi_clr_cw", cw0, 16'h0000);
      chk("ldi_clr_halted", 16'(h0), 16'h0000);

      // Sweep every opcode and flag pair; flags flip after step 2
      for (int op = 0; op < 16; op++) begin
         for (int cz = 0; cz < 4; cz++) begin
            start(4'(op), cz[1], cz[0]);
            for (int k = 0; k < 9; k++) begin
               @(posedge clk);
               #2;
               if (k >= 3) begin
                  carry = ~carry;
                  zero = ~zero;
               end
            end
         end
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
